// File: rtl/core101_pred_pkg.sv
// Shared definitions for the IFU branch predictor: opcodes, 2-bit counter
// encodings, predictor state and the saturating counter update.
package core101_pred_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } pred_state_t;

    localparam ctr_t CTR_RESET = WNT;

    // Saturating step: never wraps past strongly taken / strongly not-taken.
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != ST) r = ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) r = ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pred_imm_gen.sv
// Combinational control-flow decode: flags branch / jal and builds the
// sign-extended PC-relative immediate for whichever one matched.
module pred_imm_gen
    import core101_pred_pkg::*;
(
    input  logic [31:0] ins,
    output logic        is_branch,
    output logic        is_jal,
    output logic [31:0] imm
);

    always_comb begin
        is_branch = (ins[6:2] == OPC_BRANCH);
        is_jal    = (ins[6:2] == OPC_JAL);
        imm       = 32'd0;
        if (is_branch) begin
            imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        end else if (is_jal) begin
            imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal / gshare branch predictor: table of 2-bit counters cleared by a
// post-reset sweep, one-cycle registered prediction, separate training port.
module gshare_predictor
    import core101_pred_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int HIST_W  = 8,
    parameter int MODE    = 1
) (
    input  logic               pred_clock_in,
    input  logic               pred_reset_in,
    input  logic               pred_req_valid_in,
    input  logic [31:0]        pred_addr_in,
    input  logic [31:0]        pred_ins_in,
    output logic               pred_ready_out,
    output logic               pred_valid_out,
    output logic               pred_taken_out,
    output logic [31:0]        pred_pc_out,
    output logic [INDEX_W-1:0] pred_indx_out,
    input  logic               pred_write_enable_in,
    input  logic               pred_taken_in,
    input  logic [INDEX_W-1:0] pred_indx_in
);

    localparam int ENTRIES = 1 << INDEX_W;

    pred_state_t        state_reg;
    logic [INDEX_W-1:0] sweep_reg;
    logic [HIST_W-1:0]  hist_reg;
    logic [HIST_W-1:0]  hist_next;
    ctr_t               ctr_reg [ENTRIES];

    logic               req_fire;
    logic               upd_fire;
    logic [INDEX_W-1:0] lookup_idx;
    ctr_t               lookup_ctr;
    logic               is_branch;
    logic               is_jal;
    logic [31:0]        imm;
    logic               taken_next;
    logic [31:0]        pc_next;

    assign req_fire = pred_req_valid_in && (state_reg == READY);
    assign upd_fire = pred_write_enable_in && (state_reg == READY);

    generate
        if (MODE == 1) begin : g_gshare
            assign lookup_idx = pred_addr_in[INDEX_W+1:2] ^ INDEX_W'(hist_reg);
        end else begin : g_bimodal
            assign lookup_idx = pred_addr_in[INDEX_W+1:2];
        end

        if (HIST_W == 1) begin : g_hist_one
            assign hist_next = pred_taken_in;
        end else begin : g_hist_many
            assign hist_next = {hist_reg[HIST_W-2:0], pred_taken_in};
        end
    endgenerate

    pred_imm_gen u_imm_gen (
        .ins       (pred_ins_in),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .imm       (imm)
    );

    // Lookup reads the counter as it stands before this edge's update lands.
    assign lookup_ctr = ctr_reg[lookup_idx];
    assign taken_next = is_jal || (is_branch && lookup_ctr[1]);
    assign pc_next    = pred_addr_in + (taken_next ? imm : 32'd4);

    // Counter table: sweep writes in INIT, read-modify-write training in READY.
    always_ff @(posedge pred_clock_in) begin
        if (state_reg == INIT) begin
            ctr_reg[sweep_reg] <= CTR_RESET;
        end else if (upd_fire) begin
            ctr_reg[pred_indx_in] <= ctr_update(ctr_reg[pred_indx_in], pred_taken_in);
        end
    end

    always_ff @(posedge pred_clock_in or posedge pred_reset_in) begin
        if (pred_reset_in) begin
            state_reg      <= INIT;
            sweep_reg      <= '0;
            hist_reg       <= '0;
            pred_ready_out <= 1'b0;
            pred_valid_out <= 1'b0;
            pred_taken_out <= 1'b0;
            pred_pc_out    <= 32'd0;
            pred_indx_out  <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    sweep_reg <= sweep_reg + 1'b1;
                    if (sweep_reg == {INDEX_W{1'b1}}) begin
                        state_reg      <= READY;
                        pred_ready_out <= 1'b1;
                    end
                end
                READY: begin
                    pred_ready_out <= 1'b1;
                end
                default: begin
                    state_reg      <= INIT;
                    pred_ready_out <= 1'b0;
                end
            endcase

            if (upd_fire) begin
                hist_reg <= hist_next;
            end

            pred_valid_out <= req_fire;
            if (req_fire) begin
                pred_taken_out <= taken_next;
                pred_pc_out    <= pc_next;
                pred_indx_out  <= lookup_idx;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench: directed requests push hand-computed predictions, a
// monitor pops and compares on every pred_valid_out pulse.
module tb_gshare_predictor;

    localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
    localparam logic [31:0] BEQ_M4  = 32'hFE00_0EE3;
    localparam logic [31:0] JAL_P8  = 32'h0080_006F;
    localparam logic [31:0] ADDI_NP = 32'h0000_0013;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [3:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        a_req, a_we, a_tk, b_req, b_we, b_tk;
    logic [31:0] a_addr, a_ins, b_addr, b_ins;
    logic [3:0]  a_uidx, b_uidx;
    logic        a_ready, a_valid, a_taken, b_ready, b_valid, b_taken;
    logic [31:0] a_pc, b_pc;
    logic [3:0]  a_idx, b_idx;

    int   checks   = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    gshare_predictor #(.INDEX_W(4), .HIST_W(2), .MODE(0)) dut_a (
        .pred_clock_in        (clk),
        .pred_reset_in        (rst_a),
        .pred_req_valid_in    (a_req),
        .pred_addr_in         (a_addr),
        .pred_ins_in          (a_ins),
        .pred_ready_out       (a_ready),
        .pred_valid_out       (a_valid),
        .pred_taken_out       (a_taken),
        .pred_pc_out          (a_pc),
        .pred_indx_out        (a_idx),
        .pred_write_enable_in (a_we),
        .pred_taken_in        (a_tk),
        .pred_indx_in         (a_uidx)
    );

    gshare_predictor #(.INDEX_W(4), .HIST_W(2), .MODE(1)) dut_b (
        .pred_clock_in        (clk),
        .pred_reset_in        (rst_b),
        .pred_req_valid_in    (b_req),
        .pred_addr_in         (b_addr),
        .pred_ins_in          (b_ins),
        .pred_ready_out       (b_ready),
        .pred_valid_out       (b_valid),
        .pred_taken_out       (b_taken),
        .pred_pc_out          (b_pc),
        .pred_indx_out        (b_idx),
        .pred_write_enable_in (b_we),
        .pred_taken_in        (b_tk),
        .pred_indx_in         (b_uidx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input bit sel);
        exp_t e;
        if ((sel ? qb.size() : qa.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid dut=%s actual=valid required=idle", sel ? "B" : "A");
        end else begin
            e = sel ? qb.pop_front() : qa.pop_front();
            chk(sel ? "B_taken" : "A_taken", {31'd0, sel ? b_taken : a_taken}, {31'd0, e.taken});
            chk(sel ? "B_pc" : "A_pc", sel ? b_pc : a_pc, e.pc);
            chk(sel ? "B_idx" : "A_idx", {28'd0, sel ? b_idx : a_idx}, {28'd0, e.idx});
            $display("txn dut=%s taken=%0b pc=0x%08h idx=%0d (exp %0b 0x%08h %0d)",
                     sel ? "B" : "A", sel ? b_taken : a_taken, sel ? b_pc : a_pc,
                     sel ? b_idx : a_idx, e.taken, e.pc, e.idx);
        end
    endtask

    // One stimulus cycle: inputs set at the falling edge, sampled on the next rising edge.
    task automatic cyc(input bit sel, input logic req, input logic [31:0] addr,
                       input logic [31:0] ins, input logic we, input logic tk,
                       input logic [3:0] uidx);
        @(negedge clk);
        if (sel) begin
            b_req = req; b_addr = addr; b_ins = ins; b_we = we; b_tk = tk; b_uidx = uidx;
        end else begin
            a_req = req; a_addr = addr; a_ins = ins; a_we = we; a_tk = tk; a_uidx = uidx;
        end
    endtask

    task automatic req_upd(input bit sel, input logic [31:0] addr, input logic [31:0] ins,
                           input logic et, input logic [31:0] epc, input logic [3:0] eidx,
                           input logic we, input logic tk, input logic [3:0] uidx);
        exp_t e;
        cyc(sel, 1'b1, addr, ins, we, tk, uidx);
        e.taken = et; e.pc = epc; e.idx = eidx;
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic req(input bit sel, input logic [31:0] addr, input logic [31:0] ins,
                       input logic et, input logic [31:0] epc, input logic [3:0] eidx);
        req_upd(sel, addr, ins, et, epc, eidx, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic upd(input bit sel, input logic tk, input logic [3:0] uidx);
        cyc(sel, 1'b0, 32'd0, 32'd0, 1'b1, tk, uidx);
    endtask

    task automatic idle(input bit sel);
        cyc(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    endtask

    // Counts falling edges from reset release until ready shows; feedback stops that edge.
    task automatic count_ready(input bit sel, input int exp_n, input string name);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (sel ? b_ready : a_ready) seen = 1;
        end
        if (sel) b_we = 1'b0; else a_we = 1'b0;
        chk(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_req = 0; a_addr = 0; a_ins = 0; a_we = 0; a_tk = 0; a_uidx = 0;
        b_req = 0; b_addr = 0; b_ins = 0; b_we = 0; b_tk = 0; b_uidx = 0;

        fork
            forever begin
                @(negedge clk);
                if (a_valid) pop_check(1'b0);
                if (b_valid) pop_check(1'b1);
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_taken", {31'd0, a_taken}, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_idx", {28'd0, a_idx}, 32'd0);
        chk("rst_ready_b", {31'd0, b_ready}, 32'd0);

        // Sweep length, then a fresh-table branch.
        rst_a = 1'b0;
        count_ready(1'b0, 16, "sweep_len");
        req(1'b0, 32'h100, BEQ_P8, 1'b0, 32'h104, 4'd0);
        idle(1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-sweep restarts the count; feedback during the sweep is dropped.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_sweep_ready", {31'd0, a_ready}, 32'd0);
        rst_a = 1'b1;
        #1;
        chk("async_rst_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        a_we = 1'b1; a_tk = 1'b1; a_uidx = 4'd3;
        rst_a = 1'b0;
        count_ready(1'b0, 16, "sweep_restart");
        req(1'b0, 32'h0C, BEQ_P8, 1'b0, 32'h10, 4'd3);

        // Saturation on idx 5.
        upd(1'b0, 1'b1, 4'd5);
        upd(1'b0, 1'b1, 4'd5);
        req(1'b0, 32'h14, BEQ_P8, 1'b1, 32'h1C, 4'd5);
        upd(1'b0, 1'b0, 4'd5);
        upd(1'b0, 1'b0, 4'd5);
        upd(1'b0, 1'b0, 4'd5);
        req(1'b0, 32'h14, BEQ_P8, 1'b0, 32'h18, 4'd5);
        upd(1'b0, 1'b0, 4'd5);
        upd(1'b0, 1'b1, 4'd5);
        req(1'b0, 32'h14, BEQ_P8, 1'b0, 32'h18, 4'd5);
        upd(1'b0, 1'b1, 4'd5);
        req(1'b0, 32'h14, BEQ_P8, 1'b1, 32'h1C, 4'd5);

        // JAL, negative branch immediate with wrap, non-control opcode.
        req(1'b0, 32'h1000, JAL_P8, 1'b1, 32'h1008, 4'd0);
        req(1'b0, 32'h0, BEQ_M4, 1'b0, 32'h4, 4'd0);
        upd(1'b0, 1'b1, 4'd0);
        upd(1'b0, 1'b1, 4'd0);
        req(1'b0, 32'h0, BEQ_M4, 1'b1, 32'hFFFF_FFFC, 4'd0);
        req(1'b0, 32'h200, ADDI_NP, 1'b0, 32'h204, 4'd0);

        // Same-cycle request and update on idx 6.
        req_upd(1'b0, 32'h18, BEQ_P8, 1'b0, 32'h1C, 4'd6, 1'b1, 1'b1, 4'd6);
        req(1'b0, 32'h18, BEQ_P8, 1'b1, 32'h20, 4'd6);
        idle(1'b0);
        repeat (3) @(negedge clk);
        chk("hold_pc", a_pc, 32'h20);
        chk("hold_taken", {31'd0, a_taken}, 32'd1);

        // Gshare instance.
        @(negedge clk);
        rst_b = 1'b0;
        count_ready(1'b1, 16, "sweep_len_b");
        req(1'b1, 32'h10, BEQ_P8, 1'b0, 32'h14, 4'd4);
        upd(1'b1, 1'b1, 4'd9);
        upd(1'b1, 1'b1, 4'd9);
        req(1'b1, 32'h10, BEQ_P8, 1'b0, 32'h14, 4'd7);
        upd(1'b1, 1'b0, 4'd1);
        req(1'b1, 32'h10, BEQ_P8, 1'b0, 32'h14, 4'd6);
        req(1'b1, 32'h2C, BEQ_P8, 1'b1, 32'h34, 4'd9);
        req_upd(1'b1, 32'h10, BEQ_P8, 1'b0, 32'h14, 4'd6, 1'b1, 1'b1, 4'd1);
        req(1'b1, 32'h10, BEQ_P8, 1'b0, 32'h14, 4'd5);
        idle(1'b1);

        repeat (4) @(negedge clk);
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised dynamic branch predictor for the IFU, the successor to the 1024-entry bimodal table. It holds a power-of-two table of 2-bit saturating counters, indexed either by PC alone (bimodal) or by PC XOR a global history register (gshare). It clears its table with a post-reset sweep and returns a registered prediction plus target PC one cycle after each accepted fetch request. Execute-stage feedback trains it through a separate update port.

## Interface
- INDEX_W, 10, table index width; the table has 2^INDEX_W entries.
- HIST_W, 8, global history width; legal range 1..INDEX_W.
- MODE, 1, index mode: 0 = bimodal (PC only), 1 = gshare (PC XOR history).
- pred_clock_in  in  1  clock; all state updates on rising edge.
- pred_reset_in  in  1  reset, asynchronous, active-high.
- pred_req_valid_in  in  1  fetch request valid.
- pred_addr_in  in  32  fetch PC.
- pred_ins_in  in  32  fetched instruction.
- pred_ready_out  out  1  high when the table is initialised and requests are accepted.
- pred_valid_out  out  1  one-cycle pulse; the prediction outputs are valid.
- pred_taken_out  out  1  predicted taken.
- pred_pc_out  out  32  predicted next PC.
- pred_indx_out  out  INDEX_W  table index used for this prediction; carried down the pipe for feedback.
- pred_write_enable_in  in  1  feedback valid (conditional branches only).
- pred_taken_in  in  1  actual branch outcome.
- pred_indx_in  in  INDEX_W  index to update; this is the returned pred_indx_out.

## Operation
- State machine has two states:
  - INIT: the sweep counter writes 2'b01 (weakly not-taken) to entry 0, 1, …, 2^INDEX_W−1, one entry per cycle. After the last entry it moves to READY.
  - READY: normal operation.
- Reset values: state INIT, sweep counter 0, history 0, every output 0 (pred_ready_out 0).
- A reset asserted mid-sweep or mid-operation restarts the sweep from entry 0 and clears the history.
- Index:
  - MODE 0: idx = pred_addr_in[INDEX_W+1:2].
  - MODE 1: idx = pred_addr_in[INDEX_W+1:2] XOR zero-extended history.
- Opcode decode uses pred_ins_in[6:2]:
  - BRANCH 5'b11000: B-type immediate; taken = counter[1].
  - JAL 5'b11011: J-type immediate {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; always taken.
  - Any other opcode: not taken.
- Target PC: pred_addr_in + imm when taken, else pred_addr_in + 4. The add is 32-bit modulo and wraps silently.
- Update, accepted in READY with pred_write_enable_in high:
  - Counter at pred_indx_in saturates: increments when taken (max 2'b11), decrements when not taken (min 2'b00).
  - History shifts left with the outcome: {hist[HIST_W-2:0], pred_taken_in}.
- Updates in INIT are dropped. Requests in INIT are not accepted (pred_valid_out stays 0).

## Timing
- Sweep length: exactly 2^INDEX_W cycles after reset deassert. pred_ready_out rises on the next edge after the last write.
- Prediction latency is 1 cycle:
  - A request with valid & ready sampled at edge N produces pred_valid_out high after edge N+1, for one cycle.
  - Back-to-back requests give back-to-back results.
- Outputs hold their last value while pred_valid_out is 0.
- Request and update in the same cycle:
  - The prediction reads the pre-update counter and pre-update history.
  - The update is visible to requests sampled from the next edge on.
- Two updates to the same index on consecutive cycles both apply (read-modify-write inside one cycle).

## Structure
- Package core101_pred_pkg holds:
  - opcode constants OPC_BRANCH and OPC_JAL;
  - counter encodings SNT/WNT/WT/ST;
  - state enum {INIT, READY};
  - counter reset value WNT.
- Sub-module pred_imm_gen: combinational decode of opcode to {is_branch, is_jal, imm[31:0]}, reusable by decode.
- The table is a flop array (2·2^INDEX_W bits), not an inferred RAM, because of the reset sweep and same-cycle RMW.

## Test plan
- Reset sweep, INDEX_W=4: deassert reset and count cycles → pred_ready_out rises after 16 cycles. A requested branch at 0x100 then gives taken=0, pc=0x104. A reset pulse at cycle 8 restarts the 16-cycle count.
- Saturation, MODE 0: two taken updates to idx 5, then request a branch at PC 0x14 → taken=1. Three not-taken updates, then the same request → taken=0. A fourth not-taken leaves the counter at 2'b00.
- JAL and immediates: ins 0x0080006F (jal +8) at 0x1000 → taken=1, pc=0x1008. Branch with imm −4 at 0x0 → target wraps to 0xFFFFFFFC once trained taken.
- Gshare aliasing, MODE 1, HIST_W=2: updates taken,taken set hist=2'b11. A request at PC 0x10 → pred_indx_out=4^3=7.
- Simultaneous request and update to the same index (counter WNT, update taken) → the same-cycle prediction is not taken; the next-cycle prediction is taken.
- Non-control opcode (0x00000013) → taken=0, pc=addr+4. Updates issued during INIT leave every entry at 2'b01.
